// File: rtl/regslice_pkg.sv
// Shared definitions for the register-slice family: slice modes and
// pointer helpers used by the depth-parametrised elastic buffer.
package regslice_pkg;

  typedef enum logic [2:0] {
    MODE_NONE = 3'd0,
    MODE_FWD  = 3'd1,
    MODE_REV  = 3'd2,
    MODE_BOTH = 3'd3,
    MODE_HP   = 3'd7
  } mode_e;

  // Storage depth the AXI wrapper uses for a given slice mode.
  function automatic int unsigned mode_to_depth(mode_e mode);
    case (mode)
      MODE_BOTH, MODE_HP: return 2;
      default:            return 1;
    endcase
  endfunction

  // Fall-through setting paired with mode_to_depth: modes that must not add
  // forward latency keep the data path combinational when empty.
  function automatic bit mode_to_fall_through(mode_e mode);
    case (mode)
      MODE_NONE, MODE_REV: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Circular pointer increment; depth need not be a power of two.
  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/regslice_fifo_mem.sv
// DEPTH x DATA_WIDTH flop array: one synchronous write port, one
// asynchronous read port.
module regslice_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int ADDR_W     = 1
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write the incoming beat into the addressed entry.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read of the head entry.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/regslice_fifo.sv
// Depth-parametrised elastic buffer for one valid/ready channel, with
// optional fall-through, occupancy, almost-full and synchronous flush.
module regslice_fifo
  import regslice_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2,
  parameter int FALL_THROUGH = 0,
  parameter int AF_THRESH    = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_WIDTH-1:0]      w_data,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "regslice_fifo: DEPTH must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "regslice_fifo: DATA_WIDTH must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "regslice_fifo: AF_THRESH must be in 1..DEPTH");
  end

  logic                  r_rst_q;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_wr_en;
  logic                  w_rd_adv;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  regslice_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr),
    .i_wdata (w_data),
    .i_raddr (r_rptr),
    .o_rdata (w_mem_rdata)
  );

  // Handshake decode. w_ready depends only on registers, rst and flush, so
  // r_ready never reaches it combinationally; a pop at full reopens next cycle.
  always_comb begin
    w_empty = (r_cnt == '0);
    w_full  = (r_cnt == CNT_FULL);
    w_ready = !rst && !r_rst_q && !flush && !w_full;
    w_push  = w_valid && w_ready;
    if (FALL_THROUGH != 0 && w_empty) begin
      r_valid = w_push;
      r_data  = w_data;
    end else begin
      r_valid = !rst && !flush && !w_empty;
      r_data  = w_mem_rdata;
    end
    w_pop    = r_valid && r_ready;
    // A fall-through beat taken by the consumer never touches storage.
    w_bypass = (FALL_THROUGH != 0) && w_empty && w_pop;
    w_wr_en  = w_push && !w_bypass;
    w_rd_adv = w_pop && !w_bypass;
    count       = r_cnt;
    almost_full = (r_cnt >= CNT_AF);
  end

  // Pointer and occupancy state; rst and flush both empty the buffer.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= PTR_W'(ptr_inc(32'(r_wptr), DEPTH));
      end
      if (w_rd_adv) begin
        r_rptr <= PTR_W'(ptr_inc(32'(r_rptr), DEPTH));
      end
      case ({w_wr_en, w_rd_adv})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_r_hold : assert property (@(posedge clk) disable iff (rst || flush)
    (r_valid && !r_ready) |=> (r_valid && $stable(r_data)))
    else $error("regslice_fifo: r_valid dropped or r_data changed before pop");

  a_w_hold : assert property (@(posedge clk) disable iff (rst || flush)
    (w_valid && !w_ready) |=> (w_valid && $stable(w_data)))
    else $error("regslice_fifo: producer dropped w_valid or changed w_data before accept");
`endif

endmodule

// File: tb/tb_regslice_fifo.sv
// Directed bench for regslice_fifo: four instances covering DEPTH=4,
// DEPTH=3 (non power of two), fall-through and full-with-pop behaviour.
module tb_regslice_fifo;

  logic clk;
  logic rst;

  logic       flush_a, w_valid_a, w_ready_a, r_valid_a, r_ready_a, almost_full_a;
  logic [7:0] w_data_a, r_data_a;
  logic [2:0] count_a;

  logic       flush_b, w_valid_b, w_ready_b, r_valid_b, r_ready_b, almost_full_b;
  logic [7:0] w_data_b, r_data_b;
  logic [1:0] count_b;

  logic       flush_c, w_valid_c, w_ready_c, r_valid_c, r_ready_c, almost_full_c;
  logic [7:0] w_data_c, r_data_c;
  logic [1:0] count_c;

  logic       flush_d, w_valid_d, w_ready_d, r_valid_d, r_ready_d, almost_full_d;
  logic [7:0] w_data_d, r_data_d;
  logic [1:0] count_d;

  int n_checks;
  int n_fail;

  regslice_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(0), .AF_THRESH(3)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .w_valid(w_valid_a), .w_ready(w_ready_a),
    .w_data(w_data_a), .r_valid(r_valid_a), .r_ready(r_ready_a), .r_data(r_data_a),
    .count(count_a), .almost_full(almost_full_a));

  regslice_fifo #(.DATA_WIDTH(8), .DEPTH(3), .FALL_THROUGH(0), .AF_THRESH(2)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .w_valid(w_valid_b), .w_ready(w_ready_b),
    .w_data(w_data_b), .r_valid(r_valid_b), .r_ready(r_ready_b), .r_data(r_data_b),
    .count(count_b), .almost_full(almost_full_b));

  regslice_fifo #(.DATA_WIDTH(8), .DEPTH(2), .FALL_THROUGH(1), .AF_THRESH(1)) u_c (
    .clk(clk), .rst(rst), .flush(flush_c), .w_valid(w_valid_c), .w_ready(w_ready_c),
    .w_data(w_data_c), .r_valid(r_valid_c), .r_ready(r_ready_c), .r_data(r_data_c),
    .count(count_c), .almost_full(almost_full_c));

  regslice_fifo #(.DATA_WIDTH(8), .DEPTH(2), .FALL_THROUGH(0), .AF_THRESH(1)) u_d (
    .clk(clk), .rst(rst), .flush(flush_d), .w_valid(w_valid_d), .w_ready(w_ready_d),
    .w_data(w_data_d), .r_valid(r_valid_d), .r_ready(r_ready_d), .r_data(r_data_d),
    .count(count_d), .almost_full(almost_full_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    #1;
    n_checks++; if (count_a !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_a); end
    n_checks++; if (w_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready got %b exp 0", w_ready_a); end
    n_checks++; if (r_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid got %b exp 0", r_valid_a); end
    n_checks++; if (almost_full_a !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b exp 0", almost_full_a); end
    rst = 1'b0;
    #1;
    n_checks++; if (w_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_release_w_ready got %b exp 0", w_ready_a); end
    tick;
    n_checks++; if (w_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_after_w_ready_a got %b exp 1", w_ready_a); end
    n_checks++; if (w_ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_after_w_ready_b got %b exp 1", w_ready_b); end
    n_checks++; if (w_ready_d !== 1'b1) begin n_fail++; $display("FAIL reset_after_w_ready_d got %b exp 1", w_ready_d); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) begin
      w_valid_a = 1'b1;
      w_data_a  = 8'hA0 + 8'(i);
      #1;
      n_checks++; if (w_ready_a !== 1'b1) begin n_fail++; $display("FAIL fill_w_ready i=%0d got %b exp 1", i, w_ready_a); end
      tick;
      n_checks++; if (count_a !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, count_a, i + 1); end
      n_checks++; if (almost_full_a !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_af i=%0d got %b exp %b", i, almost_full_a, (i + 1 >= 3)); end
    end
    w_valid_a = 1'b0;
    #1;
    n_checks++; if (w_ready_a !== 1'b0) begin n_fail++; $display("FAIL full_w_ready got %b exp 0", w_ready_a); end
    r_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (r_valid_a !== 1'b1) begin n_fail++; $display("FAIL drain_r_valid i=%0d got %b exp 1", i, r_valid_a); end
      n_checks++; if (r_data_a !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL drain_r_data i=%0d got %h exp %h", i, r_data_a, 8'hA0 + 8'(i)); end
      tick;
    end
    r_ready_a = 1'b0;
    #1;
    n_checks++; if (count_a !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count_a); end
    n_checks++; if (r_valid_a !== 1'b0) begin n_fail++; $display("FAIL drain_r_valid_end got %b exp 0", r_valid_a); end
  endtask

  task automatic test_stream_depth3;
    r_ready_b = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      w_valid_b = (k < 20);
      w_data_b  = 8'(k);
      #1;
      if (k >= 1) begin
        n_checks++; if (r_valid_b !== 1'b1) begin n_fail++; $display("FAIL stream_r_valid k=%0d got %b exp 1", k, r_valid_b); end
        n_checks++; if (r_data_b !== 8'(k - 1)) begin n_fail++; $display("FAIL stream_r_data k=%0d got %0d exp %0d", k, r_data_b, k - 1); end
      end
      tick;
      n_checks++; if (count_b !== ((k < 20) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL stream_count k=%0d got %0d exp %0d", k, count_b, (k < 20) ? 1 : 0); end
    end
    w_valid_b = 1'b0;
    r_ready_b = 1'b0;
  endtask

  task automatic test_fall_through;
    w_valid_c = 1'b1;
    w_data_c  = 8'h5A;
    r_ready_c = 1'b1;
    #1;
    n_checks++; if (r_valid_c !== 1'b1) begin n_fail++; $display("FAIL ft_bypass_r_valid got %b exp 1", r_valid_c); end
    n_checks++; if (r_data_c !== 8'h5A) begin n_fail++; $display("FAIL ft_bypass_r_data got %h exp 5a", r_data_c); end
    tick;
    n_checks++; if (count_c !== 2'd0) begin n_fail++; $display("FAIL ft_bypass_count got %0d exp 0", count_c); end
    w_valid_c = 1'b0;
    r_ready_c = 1'b0;
    #1;
    n_checks++; if (r_valid_c !== 1'b0) begin n_fail++; $display("FAIL ft_idle_r_valid got %b exp 0", r_valid_c); end
    w_valid_c = 1'b1;
    w_data_c  = 8'h5A;
    #1;
    n_checks++; if (r_valid_c !== 1'b1) begin n_fail++; $display("FAIL ft_store_r_valid got %b exp 1", r_valid_c); end
    tick;
    w_valid_c = 1'b0;
    w_data_c  = 8'h00;
    #1;
    n_checks++; if (count_c !== 2'd1) begin n_fail++; $display("FAIL ft_store_count got %0d exp 1", count_c); end
    n_checks++; if (r_data_c !== 8'h5A) begin n_fail++; $display("FAIL ft_store_r_data got %h exp 5a", r_data_c); end
    tick;
    n_checks++; if (r_data_c !== 8'h5A || r_valid_c !== 1'b1) begin n_fail++; $display("FAIL ft_hold got valid=%b data=%h exp valid=1 data=5a", r_valid_c, r_data_c); end
    r_ready_c = 1'b1;
    tick;
    r_ready_c = 1'b0;
    #1;
    n_checks++; if (count_c !== 2'd0) begin n_fail++; $display("FAIL ft_pop_count got %0d exp 0", count_c); end
    n_checks++; if (r_valid_c !== 1'b0) begin n_fail++; $display("FAIL ft_pop_r_valid got %b exp 0", r_valid_c); end
  endtask

  task automatic test_full_pop;
    w_valid_d = 1'b1;
    w_data_d  = 8'h11;
    tick;
    w_data_d  = 8'h22;
    tick;
    #1;
    n_checks++; if (count_d !== 2'd2) begin n_fail++; $display("FAIL fullpop_count got %0d exp 2", count_d); end
    w_data_d  = 8'h33;
    r_ready_d = 1'b1;
    #1;
    n_checks++; if (w_ready_d !== 1'b0) begin n_fail++; $display("FAIL fullpop_w_ready got %b exp 0", w_ready_d); end
    n_checks++; if (r_data_d !== 8'h11) begin n_fail++; $display("FAIL fullpop_r_data0 got %h exp 11", r_data_d); end
    tick;
    n_checks++; if (count_d !== 2'd1) begin n_fail++; $display("FAIL fullpop_count1 got %0d exp 1", count_d); end
    n_checks++; if (w_ready_d !== 1'b1) begin n_fail++; $display("FAIL fullpop_reopen got %b exp 1", w_ready_d); end
    n_checks++; if (r_data_d !== 8'h22) begin n_fail++; $display("FAIL fullpop_r_data1 got %h exp 22", r_data_d); end
    tick;
    w_valid_d = 1'b0;
    #1;
    n_checks++; if (r_valid_d !== 1'b1 || r_data_d !== 8'h33) begin n_fail++; $display("FAIL fullpop_r_data2 got valid=%b data=%h exp valid=1 data=33", r_valid_d, r_data_d); end
    tick;
    r_ready_d = 1'b0;
    #1;
    n_checks++; if (count_d !== 2'd0) begin n_fail++; $display("FAIL fullpop_end_count got %0d exp 0", count_d); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      w_valid_a = 1'b1;
      w_data_a  = 8'hB0 + 8'(i);
      tick;
    end
    w_valid_a = 1'b0;
    #1;
    n_checks++; if (count_a !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 3", count_a); end
    flush_a   = 1'b1;
    w_valid_a = 1'b1;
    w_data_a  = 8'hC0;
    r_ready_a = 1'b1;
    #1;
    n_checks++; if (w_ready_a !== 1'b0) begin n_fail++; $display("FAIL flush_w_ready got %b exp 0", w_ready_a); end
    n_checks++; if (r_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_r_valid got %b exp 0", r_valid_a); end
    tick;
    flush_a = 1'b0;
    #1;
    n_checks++; if (count_a !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count_a); end
    n_checks++; if (r_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_after_r_valid got %b exp 0", r_valid_a); end
    n_checks++; if (w_ready_a !== 1'b1) begin n_fail++; $display("FAIL flush_after_w_ready got %b exp 1", w_ready_a); end
    n_checks++; if (almost_full_a !== 1'b0) begin n_fail++; $display("FAIL flush_after_af got %b exp 0", almost_full_a); end
    w_valid_a = 1'b0;
    r_ready_a = 1'b0;
    tick;
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 2; i++) begin
      w_valid_a = 1'b1;
      w_data_a  = 8'hD0 + 8'(i);
      tick;
    end
    w_valid_a = 1'b0;
    #1;
    n_checks++; if (count_a !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre_count got %0d exp 2", count_a); end
    rst = 1'b1;
    #1;
    n_checks++; if (r_valid_a !== 1'b0 || w_ready_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_during0 got r_valid=%b w_ready=%b exp 0 0", r_valid_a, w_ready_a); end
    tick;
    n_checks++; if (count_a !== 3'd0 || r_valid_a !== 1'b0 || w_ready_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_during1 got count=%0d r_valid=%b w_ready=%b exp 0 0 0", count_a, r_valid_a, w_ready_a); end
    tick;
    rst = 1'b0;
    #1;
    n_checks++; if (w_ready_a !== 1'b0 || count_a !== 3'd0) begin n_fail++; $display("FAIL rstmid_release got w_ready=%b count=%0d exp 0 0", w_ready_a, count_a); end
    tick;
    n_checks++; if (w_ready_a !== 1'b1 || r_valid_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got w_ready=%b r_valid=%b exp 1 0", w_ready_a, r_valid_a); end
    w_valid_a = 1'b1;
    w_data_a  = 8'hE0;
    tick;
    w_valid_a = 1'b0;
    r_ready_a = 1'b1;
    #1;
    n_checks++; if (r_valid_a !== 1'b1 || r_data_a !== 8'hE0) begin n_fail++; $display("FAIL rstmid_new_beat got valid=%b data=%h exp valid=1 data=e0", r_valid_a, r_data_a); end
    tick;
    r_ready_a = 1'b0;
    #1;
    n_checks++; if (count_a !== 3'd0 || r_valid_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_end got count=%0d r_valid=%b exp 0 0", count_a, r_valid_a); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    flush_a = 1'b0; w_valid_a = 1'b0; w_data_a = '0; r_ready_a = 1'b0;
    flush_b = 1'b0; w_valid_b = 1'b0; w_data_b = '0; r_ready_b = 1'b0;
    flush_c = 1'b0; w_valid_c = 1'b0; w_data_c = '0; r_ready_c = 1'b0;
    flush_d = 1'b0; w_valid_d = 1'b0; w_data_d = '0; r_ready_d = 1'b0;

    test_reset;
    test_fill_drain;
    test_stream_depth3;
    test_fall_through;
    test_full_pop;
    test_flush;
    test_reset_midstream;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
